// File: rtl/cache_sim_pkg.sv
// Shared types for the cache simulator front end: fixed-width integers,
// the request record and the request-queue occupancy state.
package cache_sim_pkg;

  localparam int CACHE_ADDR_W = 16;

  typedef logic [15:0] u16;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef struct packed {
    logic                    rw;
    logic [CACHE_ADDR_W-1:0] address;
  } cache_req_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } q_state_e;

endpackage

// File: rtl/cache_req_mem.sv
// Request storage: DEPTH x cache_req_t register array, one write port and one
// asynchronous read port. Contents are not reset.
module cache_req_mem
  import cache_sim_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cache_req_t    wdata,
  input  logic [AW-1:0] raddr,
  output cache_req_t    rdata
);

  cache_req_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_req_queue.sv
// In-order request FIFO between a trace/core producer and cacheSim, with flush.
// Optional statistics outputs are enabled by defining CACHE_REQ_STATS_EN.
module cache_req_queue
  import cache_sim_pkg::*;
#(
  parameter int ADDRESS_SIZE = 16,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_rw,
  input  logic [ADDRESS_SIZE-1:0]    in_address,
  input  logic                       flush,
  output logic                       req_valid,
  input  logic                       cache_ready,
  output logic                       rw,
  output logic [ADDRESS_SIZE-1:0]    address,
  output logic [$clog2(DEPTH):0]     count
`ifdef CACHE_REQ_STATS_EN
  ,
  output u32                         stat_reads,
  output u32                         stat_writes,
  output u32                         stat_overflows
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_adv_s;
  logic [PW-1:0] count_q, count_d;
  q_state_e      state_q, state_d;
  logic          in_ready_q, in_ready_d;
  cache_req_t    head_q, head_d;
  cache_req_t    wdata_s, rdata_s;
  logic          push_s, pop_s;

  cache_req_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_q[AW-1:0]),
    .wdata (wdata_s),
    .raddr (rd_adv_s[AW-1:0]),
    .rdata (rdata_s)
  );

  // Handshake qualification; flush overrides both directions
  always_comb begin
    push_s          = in_valid && in_ready_q && !flush;
    pop_s           = (state_q != EMPTY) && cache_ready && !flush;
    wdata_s.rw      = in_rw;
    wdata_s.address = in_address;
    rd_adv_s        = rd_q + PW'(pop_s);
  end

  // Next pointers, occupancy state and the head entry to present
  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    state_d    = state_q;
    in_ready_d = in_ready_q;
    head_d     = head_q;
    if (flush) begin
      wr_d = {PW{1'b0}};
      rd_d = {PW{1'b0}};
    end else begin
      wr_d = wr_q + PW'(push_s);
      rd_d = rd_adv_s;
    end
    count_d = wr_d - rd_d;
    if (wr_d == rd_d) begin
      state_d = EMPTY;
    end else if ((wr_d[PW-1] != rd_d[PW-1]) && (wr_d[AW-1:0] == rd_d[AW-1:0])) begin
      state_d = FULL;
    end else begin
      state_d = ACTIVE;
    end
    case (state_d)
      EMPTY:   in_ready_d = 1'b1;
      ACTIVE:  in_ready_d = 1'b1;
      FULL:    in_ready_d = 1'b0;
      default: in_ready_d = 1'b0;
    endcase
    // A push into a slot that becomes the head must bypass the array read
    if (!flush && (state_d != EMPTY)) begin
      if (push_s && (wr_q == rd_adv_s)) begin
        head_d = wdata_s;
      end else begin
        head_d = rdata_s;
      end
    end else begin
      head_d = head_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= {PW{1'b0}};
      rd_q       <= {PW{1'b0}};
      count_q    <= {PW{1'b0}};
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '{rw: 1'b0, address: {CACHE_ADDR_W{1'b0}}};
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign req_valid = (state_q != EMPTY);
  assign rw        = head_q.rw;
  assign address   = head_q.address;
  assign count     = count_q;

`ifdef CACHE_REQ_STATS_EN
  localparam u32 STAT_MAX = 32'hFFFF_FFFF;

  u32 reads_q, reads_d, writes_q, writes_d, ovf_q, ovf_d;

  // Saturating counters; head_q holds the entry being popped
  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    ovf_d    = ovf_q;
    if (pop_s && !head_q.rw && (reads_q != STAT_MAX)) begin
      reads_d = reads_q + 32'd1;
    end else begin
      reads_d = reads_q;
    end
    if (pop_s && head_q.rw && (writes_q != STAT_MAX)) begin
      writes_d = writes_q + 32'd1;
    end else begin
      writes_d = writes_q;
    end
    if (in_valid && !in_ready_q && (ovf_q != STAT_MAX)) begin
      ovf_d = ovf_q + 32'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Statistics registers, cleared by reset only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reads_q  <= 32'd0;
      writes_q <= 32'd0;
      ovf_q    <= 32'd0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stat_reads     = reads_q;
  assign stat_writes    = writes_q;
  assign stat_overflows = ovf_q;
`endif

endmodule

// File: doc/cache_req_queue.md
# cache_req_queue

Request queue upstream of `cacheSim`. It accepts read/write requests (`rw`, `address`) from a trace source or core model over a valid/ready handshake and buffers them in a FIFO. It presents them in order to the cache simulator, one per accepted cycle, and supports a synchronous flush. It decouples producer bursts from cache stalls.

## Interface
- `ADDRESS_SIZE`, 16, request address width; matches `cacheSim`.
- `DEPTH`, 8, FIFO entries; power of two, 2..256.
- `clk`  in  1  clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a request.
- `in_ready`  out  1  queue can accept; registered, equals not-full.
- `in_rw`  in  1  0 = read, 1 = write.
- `in_address`  in  `ADDRESS_SIZE`  request address.
- `flush`  in  1  synchronous discard of all queued entries.
- `req_valid`  out  1  head entry presented to cache.
- `cache_ready`  in  1  cache consumes head this cycle.
- `rw`  out  1  head request type.
- `address`  out  `ADDRESS_SIZE`  head request address.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: `in_valid && in_ready` at posedge writes {`in_rw`, `in_address`} at the write pointer; write pointer +1 mod DEPTH.
- Pop: `req_valid && cache_ready` at posedge advances the read pointer mod DEPTH.
- Outputs `rw`/`address` are driven from the head entry and stay stable while `req_valid && !cache_ready`. The producer must not rely on head changes without a pop.
- States: EMPTY (count 0), ACTIVE (0<count<DEPTH), FULL (count DEPTH). Next state derives from count after push/pop.
- Simultaneous push and pop in ACTIVE: count unchanged, both pointers advance.
- FULL: `in_ready`=0, so no push is accepted even if a pop occurs that cycle. `in_ready` rises the cycle after the pop.
- EMPTY: `cache_ready` is ignored. A push in EMPTY is not poppable in the same cycle.
- `flush`=1: pointers and count go to 0 at the next posedge, and any push that cycle is discarded. Flush has priority over push and pop.
- Pointers carry one extra wrap bit. full = pointers equal except the MSB; empty = pointers fully equal.
- Reset (async assert, any cycle, including mid-stall): `in_ready`=0, `req_valid`=0, `rw`=0, `address`=0, `count`=0, pointers 0, stats 0.
  - The first posedge after deassert sets `in_ready`=1.
  - Storage contents need not be cleared.

## Timing
- Push-to-present latency: 1 cycle. An entry pushed at edge N has `req_valid`=1 after edge N, with the entry visible at the head.
- Throughput: 1 request per cycle sustained in ACTIVE.
- `in_ready`, `req_valid` and `count` are registered. No combinational path from `cache_ready` to `in_ready`.
- `rw`/`address` are valid only when `req_valid`=1. Otherwise they hold their last value.

## Configuration
- `CACHE_REQ_STATS_EN` defined adds three registered u32 outputs:
  - `stat_reads`: popped reads.
  - `stat_writes`: popped writes.
  - `stat_overflows`: cycles with `in_valid && !in_ready`.
- All three counters saturate at 2^32-1, clear on reset only, and are not affected by `flush`.
- Undefined: the ports and counters are absent, with no other behaviour change.

## Structure
- Shared package `cache_sim_pkg`:
  - typedefs `u16`, `u32`, `u64`.
  - `cache_req_t` packed struct {`rw`, `address`}, with `address` sized by a package constant `CACHE_ADDR_W` = 16.
  - queue state enum {EMPTY, ACTIVE, FULL}.
- One sub-module `cache_req_mem`: DEPTH × `cache_req_t` register array with one write port and one asynchronous read port.
- Pointer, state and stats logic lives in `cache_req_queue`.

## Test plan
- Reset and single entry:
  - After reset, push {1, 16'h1A2B}. `req_valid`=1 next cycle with `rw`=1, `address`=16'h1A2B.
  - `cache_ready`=1 then gives `count`=0 and `req_valid`=0.
- Fill to full:
  - DEPTH=8 with `cache_ready`=0, push 8 entries. `count`=8 and `in_ready`=0.
  - A 9th push is held off and `stat_overflows` increments.
  - Then pop 8 with `cache_ready`=1. Addresses come out in push order 16'h0000..16'h0007.
- Stall stability: `cache_ready`=0 for 5 cycles with head 16'hBEEF. `rw`/`address` are unchanged all 5 cycles.
- Concurrent push and pop with `count`=3: `count` stays 3 over 100 cycles, and pointers wrap past DEPTH with no data loss.
- Flush: `count`=5 plus flush plus a simultaneous push gives `count`=0 and `req_valid`=0 next cycle, with the pushed entry discarded.
- Async reset mid-stall: assert `reset_n`=0 between edges. All outputs are 0 immediately, and `stat_reads`/`stat_writes` are 0.
